// File: rtl/uart_tx_controller.sv
// uart_tx_controller
//   Device-to-host response path. A device opens a packet with a start pulse
//   (command + size), then supplies `size` data bytes. Each packet is framed as
//   [command][size][data...] into an internal TX FIFO, which is drained one byte
//   at a time into a byte-level UART transmitter using a start/busy handshake.
//
//   ADDR_WIDTH must be >= 9 so that one maximum packet (257 bytes) fits.
//
//   Optional feature macro: UART_TX_TIMEOUT_PAD_EN
//     When defined, an open packet whose data stalls for TIMEOUT_MS ticks of
//     signal_1ms is completed with 0x00 pad bytes so host-side framing survives.
//     When undefined, signal_1ms is unused and an open packet waits forever.

module uart_tx_controller #(
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT_MS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dev_tx_start,
    input  logic [7:0] dev_tx_command,
    input  logic [7:0] dev_tx_size,
    output logic       dev_tx_ready,
    input  logic       dev_tx_data_signal,
    input  logic [7:0] dev_tx_data,
    output logic       dev_tx_data_ready,
    output logic       uart_tx_start,
    output logic [7:0] uart_tx_byte,
    input  logic       uart_tx_busy,
    input  logic       signal_1ms,
    output logic       tx_idle
);

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    // A new packet is only accepted when a full 257-byte packet still fits.
    localparam logic [ADDR_WIDTH:0] READY_MAX = (ADDR_WIDTH + 1)'(DEPTH - 257);
    localparam logic [ADDR_WIDTH:0] USED_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [15:0]         TMO_LIMIT = 16'(TIMEOUT_MS);

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_SIZE = 2'd1,
        IN_DATA = 2'd2
`ifdef UART_TX_TIMEOUT_PAD_EN
        ,
        IN_PAD  = 2'd3
`endif
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_WAIT = 2'd1,
        OUT_SEND = 2'd2,
        OUT_HOLD = 2'd3
    } out_state_t;

    // Input side state
    in_state_t in_state_q;
    logic [7:0] size_q;
    logic [7:0] byte_cnt_q;
`ifdef UART_TX_TIMEOUT_PAD_EN
    logic [15:0] tmo_cnt_q;
`endif

    // FIFO state
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   used_q;
    logic [ADDR_WIDTH:0]   used_d;
    logic [7:0]            rd_data_p1;
    logic [7:0]            q_p2;
    logic                  wr_en_d;
    logic [7:0]            wr_data_d;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  wr_ok;
    logic                  rd_ok;

    // Output side state
    out_state_t out_state_q;
    logic       rdreq_q;
    logic       wait_cnt_q;
    logic       hold_wait_q;
    logic       uart_tx_start_q;
    logic [7:0] uart_tx_byte_q;
    logic       tx_idle_q;

    assign fifo_empty = (used_q == {(ADDR_WIDTH + 1){1'b0}});
    assign fifo_full  = used_q[ADDR_WIDTH];
    assign wr_ok      = wr_en_d && !fifo_full;
    assign rd_ok      = rdreq_q && !fifo_empty;

    assign dev_tx_ready      = (in_state_q == IN_IDLE) && (used_q <= READY_MAX);
    assign dev_tx_data_ready = (in_state_q == IN_DATA);
    assign uart_tx_start     = uart_tx_start_q;
    assign uart_tx_byte      = uart_tx_byte_q;
    assign tx_idle           = tx_idle_q;

`ifndef UART_TX_TIMEOUT_PAD_EN
    logic unused_tick;
    assign unused_tick = signal_1ms ^ TMO_LIMIT[0];
`endif

    // Decode the FIFO write (byte and strobe) implied by the input FSM this cycle
    always_comb begin
        wr_en_d   = 1'b0;
        wr_data_d = 8'h00;
        case (in_state_q)
            IN_IDLE: begin
                if (dev_tx_start && dev_tx_ready) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = dev_tx_command;
                end
            end
            IN_SIZE: begin
                wr_en_d   = 1'b1;
                wr_data_d = size_q;
            end
            IN_DATA: begin
                if (dev_tx_data_signal) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = dev_tx_data;
                end
            end
`ifdef UART_TX_TIMEOUT_PAD_EN
            IN_PAD: begin
                wr_en_d   = 1'b1;
                wr_data_d = 8'h00;
            end
`endif
            default: begin
                wr_en_d   = 1'b0;
                wr_data_d = 8'h00;
            end
        endcase
    end

    // Input FSM: frames command, size and data bytes into the FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            in_state_q <= IN_IDLE;
            size_q     <= 8'h00;
            byte_cnt_q <= 8'h00;
`ifdef UART_TX_TIMEOUT_PAD_EN
            tmo_cnt_q  <= 16'h0000;
`endif
        end else begin
            case (in_state_q)
                IN_IDLE: begin
                    if (dev_tx_start && dev_tx_ready) begin
                        size_q     <= dev_tx_size;
                        in_state_q <= IN_SIZE;
                    end
                end
                IN_SIZE: begin
                    if (size_q == 8'h00) begin
                        in_state_q <= IN_IDLE;
                    end else begin
                        byte_cnt_q <= 8'h00;
`ifdef UART_TX_TIMEOUT_PAD_EN
                        tmo_cnt_q  <= 16'h0000;
`endif
                        in_state_q <= IN_DATA;
                    end
                end
                IN_DATA: begin
                    if (dev_tx_data_signal) begin
                        byte_cnt_q <= byte_cnt_q + 8'd1;
`ifdef UART_TX_TIMEOUT_PAD_EN
                        tmo_cnt_q  <= 16'h0000;
`endif
                        if (byte_cnt_q + 8'd1 == size_q) begin
                            in_state_q <= IN_IDLE;
                        end
                    end
`ifdef UART_TX_TIMEOUT_PAD_EN
                    else if (tmo_cnt_q >= TMO_LIMIT) begin
                        in_state_q <= IN_PAD;
                    end else if (signal_1ms) begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end
`ifdef UART_TX_TIMEOUT_PAD_EN
                IN_PAD: begin
                    // One zero byte per clock until the declared size is met
                    byte_cnt_q <= byte_cnt_q + 8'd1;
                    if (byte_cnt_q + 8'd1 == size_q) begin
                        in_state_q <= IN_IDLE;
                    end
                end
`endif
                default: begin
                    in_state_q <= IN_IDLE;
                end
            endcase
        end
    end

    // Next FIFO occupancy: simultaneous write and read leave it unchanged
    always_comb begin
        used_d = used_q;
        if (wr_ok && !rd_ok) begin
            used_d = used_q + USED_ONE;
        end else if (!wr_ok && rd_ok) begin
            used_d = used_q - USED_ONE;
        end
    end

    // FIFO pointers and occupancy; a write while full is a design error
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q <= {ADDR_WIDTH{1'b0}};
            used_q   <= {(ADDR_WIDTH + 1){1'b0}};
        end else begin
            assert (!(wr_en_d && fifo_full));
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            used_q <= used_d;
        end
    end

    // FIFO storage with a two-stage read: q is valid two clocks after rdreq
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data_d;
        end
        if (rd_ok) begin
            rd_data_p1 <= mem[rd_ptr_q];
        end
        q_p2 <= rd_data_p1;
    end

    // Output FSM: fetch one byte, hand it to the UART, wait for it to finish
    always_ff @(posedge clock) begin
        if (reset) begin
            out_state_q     <= OUT_IDLE;
            rdreq_q         <= 1'b0;
            wait_cnt_q      <= 1'b0;
            hold_wait_q     <= 1'b0;
            uart_tx_start_q <= 1'b0;
            uart_tx_byte_q  <= 8'h00;
        end else begin
            rdreq_q         <= 1'b0;
            uart_tx_start_q <= 1'b0;
            case (out_state_q)
                OUT_IDLE: begin
                    if (!fifo_empty && !uart_tx_busy) begin
                        rdreq_q     <= 1'b1;
                        wait_cnt_q  <= 1'b0;
                        out_state_q <= OUT_WAIT;
                    end
                end
                OUT_WAIT: begin
                    if (wait_cnt_q) begin
                        out_state_q <= OUT_SEND;
                    end else begin
                        wait_cnt_q <= 1'b1;
                    end
                end
                OUT_SEND: begin
                    uart_tx_byte_q  <= q_p2;
                    uart_tx_start_q <= 1'b1;
                    hold_wait_q     <= 1'b0;
                    out_state_q     <= OUT_HOLD;
                end
                OUT_HOLD: begin
                    // Skip one clock so a late-rising busy is seen before release
                    if (!hold_wait_q) begin
                        hold_wait_q <= 1'b1;
                    end else if (!uart_tx_busy) begin
                        out_state_q <= OUT_IDLE;
                    end
                end
                default: begin
                    out_state_q <= OUT_IDLE;
                end
            endcase
        end
    end

    // Registered idle indication for the whole block
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_idle_q <= 1'b0;
        end else begin
            tx_idle_q <= (in_state_q == IN_IDLE) && (out_state_q == OUT_IDLE) &&
                         fifo_empty && !uart_tx_busy;
        end
    end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Testbench for uart_tx_controller: randomized packets checked against an
// expected byte stream built from the packet framing rules.
`timescale 1ns/1ps
module tb_uart_tx_controller;

    localparam int AW  = 9;
    localparam int TMO = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dev_tx_start = 1'b0;
    logic [7:0] dev_tx_command = 8'h00;
    logic [7:0] dev_tx_size = 8'h00;
    logic       dev_tx_ready;
    logic       dev_tx_data_signal = 1'b0;
    logic [7:0] dev_tx_data = 8'h00;
    logic       dev_tx_data_ready;
    logic       uart_tx_start;
    logic [7:0] uart_tx_byte;
    logic       uart_tx_busy = 1'b0;
    logic       signal_1ms = 1'b0;
    logic       tx_idle;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] pkt[256];
    int busy_len = 0;
    bit busy_force = 1'b0;
    int busy_cnt = 0;
    int busy_viol = 0;
    int n_starts = 0;
    int first_start_cyc = -1;
    int last_accept_cyc = 0;

    uart_tx_controller #(.ADDR_WIDTH(AW), .TIMEOUT_MS(TMO)) dut (
        .clock(clock), .reset(reset),
        .dev_tx_start(dev_tx_start), .dev_tx_command(dev_tx_command),
        .dev_tx_size(dev_tx_size), .dev_tx_ready(dev_tx_ready),
        .dev_tx_data_signal(dev_tx_data_signal), .dev_tx_data(dev_tx_data),
        .dev_tx_data_ready(dev_tx_data_ready),
        .uart_tx_start(uart_tx_start), .uart_tx_byte(uart_tx_byte),
        .uart_tx_busy(uart_tx_busy), .signal_1ms(signal_1ms), .tx_idle(tx_idle)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // UART model: records transmitted bytes and holds busy for busy_len clocks
    initial forever begin
        @(negedge clock);
        if (uart_tx_start === 1'b1) begin
            if (uart_tx_busy) busy_viol++;
            got_q.push_back(uart_tx_byte);
            n_starts++;
            if (first_start_cyc < 0) first_start_cyc = cyc;
            busy_cnt = busy_len;
        end
        if (busy_force) uart_tx_busy = 1'b1;
        else if (busy_cnt > 0) begin
            uart_tx_busy = 1'b1;
            busy_cnt--;
        end else uart_tx_busy = 1'b0;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: cycles=%0d required=<90000", cyc);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        n_starts = 0;
        busy_viol = 0;
        first_start_cyc = -1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        dev_tx_start = 1'b0;
        dev_tx_data_signal = 1'b0;
        signal_1ms = 1'b0;
        tick(n);
        clear_model();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (dev_tx_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
    endtask

    task automatic wait_data_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dev_tx_data_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
    endtask

    task automatic open_packet(input logic [7:0] cmd, input logic [7:0] size, output bit ok);
        wait_ready(ok);
        if (!ok) return;
        dev_tx_start = 1'b1;
        dev_tx_command = cmd;
        dev_tx_size = size;
        last_accept_cyc = cyc + 1;
        exp_q.push_back(cmd);
        exp_q.push_back(size);
        @(negedge clock);
        dev_tx_start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, output bit ok);
        wait_data_ready(ok);
        if (!ok) return;
        dev_tx_data_signal = 1'b1;
        dev_tx_data = d;
        exp_q.push_back(d);
        @(negedge clock);
        dev_tx_data_signal = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] cmd, input int size, input int max_gap, output bit ok);
        logic [7:0] sz;
        sz = size[7:0];
        open_packet(cmd, sz, ok);
        if (!ok) return;
        for (int i = 0; i < size; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clock);
            push_byte(pkt[i], ok);
            if (!ok) return;
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clock);
            if (got_q.size() >= exp_q.size() && tx_idle === 1'b1) begin ok = 1'b1; break; end
        end
        tick(15);
    endtask

    task automatic test_reset();
        do_reset(3);
        n_cmp++; if (uart_tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got=%b want=0", uart_tx_start); end
        n_cmp++; if (uart_tx_byte !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got=%02h want=00", uart_tx_byte); end
        n_cmp++; if (dev_tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL rst_data_ready: got=%b want=0", dev_tx_data_ready); end
        n_cmp++; if (tx_idle !== 1'b0) begin n_fail++; $display("FAIL rst_tx_idle: got=%b want=0", tx_idle); end
        n_cmp++; if (dev_tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got=%b want=1", dev_tx_ready); end
        reset = 1'b0;
        tick(3);
        n_cmp++; if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle_after: got=%b want=1", tx_idle); end
    endtask

    task automatic test_zero_size();
        bit ok;
        clear_model();
        busy_len = 0;
        send_packet(8'h12, 0, 0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL zero_accept: got=timeout want=accepted"); end
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL zero_drain: got=%0d bytes want=%0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL zero_len: got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_byte[%0d]: got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (n_starts !== 2) begin n_fail++; $display("FAIL zero_starts: got=%0d want=2", n_starts); end
        n_cmp++; if (first_start_cyc - last_accept_cyc !== 4) begin n_fail++; $display("FAIL zero_latency: got=%0d want=4", first_start_cyc - last_accept_cyc); end
        n_cmp++; if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL zero_idle: got=%b want=1", tx_idle); end
    endtask

    task automatic test_busy_stream();
        bit ok;
        clear_model();
        busy_len = 10;
        pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
        send_packet(8'hA5, 3, 0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL busy_accept: got=timeout want=accepted"); end
        wait_drain(ok);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL busy_len: got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_byte[%0d]: got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (n_starts !== 5) begin n_fail++; $display("FAIL busy_starts: got=%0d want=5", n_starts); end
        n_cmp++; if (busy_viol !== 0) begin n_fail++; $display("FAIL busy_overlap: got=%0d want=0", busy_viol); end
        // Randomized packets with random UART busy lengths and data gaps
        clear_model();
        for (int k = 0; k < 6; k++) begin
            int sz;
            busy_len = $urandom_range(0, 6);
            sz = $urandom_range(0, 24);
            for (int j = 0; j < sz; j++) pkt[j] = 8'($urandom);
            send_packet(8'($urandom), sz, 2, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_accept[%0d]: got=timeout want=accepted", k); end
        end
        wait_drain(ok);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_len: got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (busy_viol !== 0) begin n_fail++; $display("FAIL rand_overlap: got=%0d want=0", busy_viol); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit exp_ready;
        clear_model();
        busy_len = 2;
        busy_force = 1'b1;
        tick(3);
        n_cmp++; if (dev_tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_pre: got=%b want=1", dev_tx_ready); end
        for (int j = 0; j < 255; j++) pkt[j] = 8'($urandom);
        send_packet(8'($urandom), 255, 0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_accept1: got=timeout want=accepted"); end
        tick(4);
        // Nothing transmitted, so every accepted byte is still queued
        exp_ready = ((exp_q.size() - got_q.size()) <= ((1 << AW) - 257));
        n_cmp++; if (dev_tx_ready !== exp_ready) begin n_fail++; $display("FAIL b2b_ready_full: got=%b want=%b", dev_tx_ready, exp_ready); end
        n_cmp++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL b2b_sent_busy: got=%0d want=0", got_q.size()); end
        // A start while not ready must be ignored
        dev_tx_start = 1'b1; dev_tx_command = 8'hEE; dev_tx_size = 8'h00;
        @(negedge clock);
        dev_tx_start = 1'b0;
        tick(3);
        busy_force = 1'b0;
        for (int j = 0; j < 255; j++) pkt[j] = 8'($urandom);
        send_packet(8'($urandom), 255, 1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_accept2: got=timeout want=accepted"); end
        wait_drain(ok);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte[%0d]: got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (busy_viol !== 0) begin n_fail++; $display("FAIL b2b_overlap: got=%0d want=0", busy_viol); end
    endtask

    task automatic test_ignored();
        bit ok;
        clear_model();
        busy_len = 2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (dev_tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL ign_dr_idle: got=%b want=0", dev_tx_data_ready); end
            dev_tx_data_signal = 1'b1; dev_tx_data = 8'($urandom);
            @(negedge clock);
            dev_tx_data_signal = 1'b0;
        end
        open_packet(8'h3C, 8'h03, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ign_accept: got=timeout want=accepted"); end
        for (int k = 0; k < 3; k++) begin
            wait_data_ready(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL ign_data_ready[%0d]: got=timeout want=1", k); end
            n_cmp++; if (dev_tx_ready !== 1'b0) begin n_fail++; $display("FAIL ign_ready_data: got=%b want=0", dev_tx_ready); end
            dev_tx_start = 1'b1; dev_tx_command = 8'hEE; dev_tx_size = 8'h09;
            dev_tx_data_signal = 1'b1; dev_tx_data = 8'($urandom);
            exp_q.push_back(dev_tx_data);
            @(negedge clock);
            dev_tx_start = 1'b0; dev_tx_data_signal = 1'b0;
        end
        n_cmp++; if (dev_tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL ign_dr_drop: got=%b want=0", dev_tx_data_ready); end
        dev_tx_data_signal = 1'b1; dev_tx_data = 8'h99;
        @(negedge clock);
        dev_tx_data_signal = 1'b0;
        wait_drain(ok);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ign_len: got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ign_byte[%0d]: got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_model();
        busy_len = 3;
        open_packet(8'h5A, 8'h05, ok);
        push_byte(8'($urandom), ok);
        push_byte(8'($urandom), ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_bytes: got=timeout want=accepted"); end
        do_reset(1);
        n_cmp++; if (uart_tx_start !== 1'b0) begin n_fail++; $display("FAIL rmid_start: got=%b want=0", uart_tx_start); end
        n_cmp++; if (uart_tx_byte !== 8'h00) begin n_fail++; $display("FAIL rmid_byte: got=%02h want=00", uart_tx_byte); end
        n_cmp++; if (dev_tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_dr: got=%b want=0", dev_tx_data_ready); end
        n_cmp++; if (tx_idle !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got=%b want=0", tx_idle); end
        n_cmp++; if (dev_tx_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got=%b want=1", dev_tx_ready); end
        reset = 1'b0;
        pkt[0] = 8'h44;
        send_packet(8'h33, 1, 0, ok);
        wait_drain(ok);
        n_cmp++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL rmid_len: got=%0d want=3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_byte[%0d]: got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_model();
        busy_len = 1;
        open_packet(8'h07, 8'h04, ok);
        push_byte(8'hAA, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL tmo_accept: got=timeout want=accepted"); end
        for (int k = 0; k < 3; k++) begin
            tick(15);
            signal_1ms = 1'b1;
            @(negedge clock);
            signal_1ms = 1'b0;
        end
        tick(20);
`ifdef UART_TX_TIMEOUT_PAD_EN
        for (int k = 0; k < 3; k++) exp_q.push_back(8'h00);
        wait_drain(ok);
        n_cmp++; if (dev_tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL tmo_dr: got=%b want=0", dev_tx_data_ready); end
`else
        tick(40);
        n_cmp++; if (dev_tx_data_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_dr: got=%b want=1", dev_tx_data_ready); end
`endif
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL tmo_len: got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tmo_byte[%0d]: got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
`ifndef UART_TX_TIMEOUT_PAD_EN
        do_reset(2);
        reset = 1'b0;
        tick(2);
`endif
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_zero_size();
        test_busy_stream();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
